// File: rtl/clkmeas.sv
// clkmeas: measures period and high time of a slow input in clk cycles,
// flags near-50% duty and counter-saturation timeouts.
`timescale 1ns/1ps
module clkmeas #(
    parameter int unsigned width       = 16,
    parameter int unsigned sync_stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [width-1:0] period,
    output logic [width-1:0] high,
    output logic             sym,
    output logic             valid,
    output logic             timeout
);
    localparam int unsigned      cw      = width + 1;
    localparam logic [width-1:0] cnt_max = '1;

    typedef enum logic [1:0] {st_arm, st_hi, st_lo} state_t;

    state_t                 state;
    state_t                 state_n;
    logic [sync_stages-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic                   sat;
    logic [width-1:0]       cnt;
    logic [width-1:0]       hcap;
    logic                   cap_hi;
    logic                   meas;
    logic                   tmo;
    logic [cw-1:0]          twice_h;
    logic [cw-1:0]          per_x;
    logic [cw-1:0]          diff;
    logic                   sym_n;

    // synchronizer chain plus edge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[sync_stages-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign sat  = (cnt == cnt_max);

    // cycle counter: restarts at 1 on every rise, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= width'(1);
        end else if (!sat) begin
            cnt <= cnt + width'(1);
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_arm;
        end else begin
            state <= state_n;
        end
    end

    // next-state and capture controls; an edge beats saturation in the same cycle
    always_comb begin
        state_n = state;
        cap_hi  = 1'b0;
        meas    = 1'b0;
        tmo     = 1'b0;
        case (state)
            st_arm: begin
                if (rise) state_n = st_hi;
            end
            st_hi: begin
                if (fall) begin
                    cap_hi  = 1'b1;
                    state_n = st_lo;
                end else if (sat) begin
                    tmo     = 1'b1;
                    state_n = st_arm;
                end
            end
            st_lo: begin
                if (rise) begin
                    meas    = 1'b1;
                    state_n = st_hi;
                end else if (sat) begin
                    tmo     = 1'b1;
                    state_n = st_arm;
                end
            end
            default: state_n = st_arm;
        endcase
    end

    // symmetry test |2*high - period| <= 1 on width+1 bits, from the values being captured
    always_comb begin
        twice_h = {hcap, 1'b0};
        per_x   = {1'b0, cnt};
        diff    = (twice_h >= per_x) ? (twice_h - per_x) : (per_x - twice_h);
        sym_n   = (diff <= cw'(1));
    end

    // result registers; sym is captured alongside period/high so it tracks them exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcap    <= '0;
            period  <= '0;
            high    <= '0;
            sym     <= 1'b0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= meas;
            if (cap_hi) hcap <= cnt;
            if (meas) begin
                period  <= cnt;
                high    <= hcap;
                sym     <= sym_n;
                timeout <= 1'b0;
            end else if (tmo) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
